// File: rtl/pad_in_filter.sv
// pad_in_filter: per-pad synchroniser, optional debounce and edge pulses
// between the padring pad_in vector and the chip cio_*_i inputs.
//
// Ports:
//   clk_i           block clock
//   rst_ni          synchronous active-low reset
//   pad_in_i        raw asynchronous pad inputs
//   filter_en_i     per-pad debounce enable
//   filter_thresh_i shared debounce threshold T (level must persist T+1 cycles)
//   pad_in_o        conditioned pad values (registered)
//   rise_o/fall_o   one-cycle pulses the cycle after pad_in_o changes
//
// Optional macro PAD_IN_FILTER_WKUP_EN adds:
//   wkup_en_i       per-pad wakeup enable
//   wkup_clr_i      clears the sticky wakeup request
//   wkup_req_o      sticky wakeup request (set wins over clear)
module pad_in_filter #(
    parameter int                NPads      = 64,
    parameter int                CntW       = 8,
    parameter int                SyncStages = 2,
    parameter logic [NPads-1:0]  ResetVal   = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NPads-1:0] pad_in_i,
    input  logic [NPads-1:0] filter_en_i,
    input  logic [CntW-1:0]  filter_thresh_i,
    output logic [NPads-1:0] pad_in_o,
    output logic [NPads-1:0] rise_o,
    output logic [NPads-1:0] fall_o
`ifdef PAD_IN_FILTER_WKUP_EN
    ,
    input  logic [NPads-1:0] wkup_en_i,
    input  logic             wkup_clr_i,
    output logic             wkup_req_o
`endif
);

    logic [NPads-1:0] sync_q [SyncStages];
    logic [NPads-1:0] synced;
    logic [NPads-1:0] stable_q;
    logic [NPads-1:0] stable_d;
    logic [NPads-1:0] stable_dly;
    logic [CntW-1:0]  cnt_q [NPads];
    logic [CntW-1:0]  cnt_d [NPads];

    // Synchroniser chain, resettable like every other flop here.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) begin
                sync_q[s] <= ResetVal;
            end
        end else begin
            sync_q[0] <= pad_in_i;
            for (int s = 1; s < SyncStages; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SyncStages-1];

    // Debounce: a mismatch is accepted once the count has reached T.
    // Using ">=" lets a lowered threshold take effect on the next
    // mismatch cycle; the count only grows while below T, so it
    // can never wrap.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NPads; i++) begin
            cnt_d[i] = '0;
            if (!filter_en_i[i]) begin
                stable_d[i] = synced[i];
            end else if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] >= filter_thresh_i) begin
                    stable_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stable_q   <= ResetVal;
            stable_dly <= ResetVal;
            rise_o     <= '0;
            fall_o     <= '0;
            for (int i = 0; i < NPads; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q   <= stable_d;
            stable_dly <= stable_q;
            rise_o     <= stable_q & ~stable_dly;
            fall_o     <= ~stable_q & stable_dly;
            for (int i = 0; i < NPads; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pad_in_o = stable_q;

`ifdef PAD_IN_FILTER_WKUP_EN
    // Sticky request; a new enabled edge wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wkup_req_o <= 1'b0;
        end else if (|((rise_o | fall_o) & wkup_en_i)) begin
            wkup_req_o <= 1'b1;
        end else if (wkup_clr_i) begin
            wkup_req_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pad_in_filter.sv
// tb_pad_in_filter: directed scenarios plus randomized traffic checked
// against a behavioural per-pad model of pad_in_filter.
module tb_pad_in_filter;

    localparam int          NP = 64;
    localparam int          CW = 8;
    localparam int          SS = 2;
    localparam logic [63:0] RV = 64'h1;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [NP-1:0] pad_in;
    logic [NP-1:0] filter_en;
    logic [CW-1:0] thresh;
    logic [NP-1:0] pad_out;
    logic [NP-1:0] rise;
    logic [NP-1:0] fall;
    logic [NP-1:0] wkup_en;
    logic          wkup_clr;
    logic          wkup_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pad_in_filter #(
        .NPads      (NP),
        .CntW       (CW),
        .SyncStages (SS),
        .ResetVal   (RV)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .pad_in_i        (pad_in),
        .filter_en_i     (filter_en),
        .filter_thresh_i (thresh),
        .pad_in_o        (pad_out),
        .rise_o          (rise),
        .fall_o          (fall)
`ifdef PAD_IN_FILTER_WKUP_EN
        ,
        .wkup_en_i       (wkup_en),
        .wkup_clr_i      (wkup_clr),
        .wkup_req_o      (wkup_req)
`endif
    );

`ifndef PAD_IN_FILTER_WKUP_EN
    assign wkup_req = 1'b0;
`endif

    // Behavioural model: input samples travel through a delay queue;
    // each pad remembers how many consecutive cycles the delayed value
    // has disagreed with the accepted value.
    logic [NP-1:0] m_hist[$];
    logic [NP-1:0] m_stable;
    logic [NP-1:0] m_prev;
    logic [NP-1:0] m_rise;
    logic [NP-1:0] m_fall;
    int            m_run[NP];
    logic          m_wk;

    always @(posedge clk) begin
        logic [NP-1:0] sy;
        if (!rst_ni) begin
            m_hist.delete();
            for (int s = 0; s < SS; s++) m_hist.push_back(RV);
            m_stable = RV;
            m_prev   = RV;
            m_rise   = '0;
            m_fall   = '0;
            m_wk     = 1'b0;
            for (int p = 0; p < NP; p++) m_run[p] = 0;
        end else begin
`ifdef PAD_IN_FILTER_WKUP_EN
            if (|((m_rise | m_fall) & wkup_en)) m_wk = 1'b1;
            else if (wkup_clr) m_wk = 1'b0;
`endif
            m_rise = m_stable & ~m_prev;
            m_fall = ~m_stable & m_prev;
            m_prev = m_stable;
            sy = m_hist[SS-1];
            for (int p = 0; p < NP; p++) begin
                if (!filter_en[p]) begin
                    m_stable[p] = sy[p];
                    m_run[p] = 0;
                end else if (sy[p] == m_stable[p]) begin
                    m_run[p] = 0;
                end else if (m_run[p] >= int'(thresh)) begin
                    m_stable[p] = sy[p];
                    m_run[p] = 0;
                end else begin
                    m_run[p] = m_run[p] + 1;
                end
            end
            m_hist.push_front(pad_in);
            void'(m_hist.pop_back());
        end
    end

    task automatic test_reset();
        pad_in    = '1;
        filter_en = '0;
        thresh    = '0;
        wkup_en   = '0;
        wkup_clr  = 1'b0;
        rst_ni    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pad_out !== RV) begin
            errors++;
            $display("FAIL reset_val got %h want %h", pad_out, RV);
        end
        checks++;
        if ((rise | fall) !== '0) begin
            errors++;
            $display("FAIL reset_pulse got %h want 0", rise | fall);
        end
        rst_ni = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (pad_out !== RV) begin
                errors++;
                $display("FAIL reset_hold c%0d got %h want %h", c, pad_out, RV);
            end
        end
        @(negedge clk);
        checks++;
        if (pad_out !== '1 || rise !== '0) begin
            errors++;
            $display("FAIL reset_rel got %h/%h want ones/0", pad_out, rise);
        end
        @(negedge clk);
        checks++;
        if (rise !== ~64'h1 || fall !== '0) begin
            errors++;
            $display("FAIL reset_rise got %h/%h want %h/0", rise, fall, ~64'h1);
        end
        @(negedge clk);
        checks++;
        if (rise !== '0) begin
            errors++;
            $display("FAIL reset_rise_w got %h want 0", rise);
        end
        checks++;
        if (wkup_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_wkup got %b want 0", wkup_req);
        end
    endtask

    task automatic test_bypass();
        pad_in[5] = 1'b0;
        repeat (6) @(negedge clk);
        pad_in[5] = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (pad_out[5] !== 1'b0) begin
                errors++;
                $display("FAIL byp_early c%0d got %b want 0", c, pad_out[5]);
            end
        end
        @(negedge clk);
        checks++;
        if (pad_out[5] !== 1'b1 || rise[5] !== 1'b0) begin
            errors++;
            $display("FAIL byp_lat got %b/%b want 1/0", pad_out[5], rise[5]);
        end
        @(negedge clk);
        checks++;
        if (rise[5] !== 1'b1) begin
            errors++;
            $display("FAIL byp_rise got %b want 1", rise[5]);
        end
        @(negedge clk);
        checks++;
        if (rise[5] !== 1'b0) begin
            errors++;
            $display("FAIL byp_width got %b want 0", rise[5]);
        end
    endtask

    task automatic test_debounce();
        filter_en = 64'h1 << 5;
        thresh    = 8'd4;
        pad_in[5] = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (pad_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL deb_pre got %b want 0", pad_out[5]);
        end
        pad_in[5] = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (pad_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL deb_early got %b want 0", pad_out[5]);
        end
        @(negedge clk);
        checks++;
        if (pad_out[5] !== 1'b1) begin
            errors++;
            $display("FAIL deb_accept got %b want 1", pad_out[5]);
        end
        @(negedge clk);
        checks++;
        if (rise[5] !== 1'b1) begin
            errors++;
            $display("FAIL deb_rise got %b want 1", rise[5]);
        end
        pad_in[5] = 1'b0;
        repeat (10) @(negedge clk);
        pad_in[5] = 1'b1;
        repeat (4) @(negedge clk);
        pad_in[5] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (pad_out[5] !== 1'b0 || rise[5] !== 1'b0) begin
                errors++;
                $display("FAIL deb_short c%0d got %b/%b want 0/0",
                         c, pad_out[5], rise[5]);
            end
        end
    endtask

    task automatic test_glitch();
        logic [8:0] pat;
        int first;
        pat   = 9'b111110111;
        first = 0;
        thresh = 8'd4;
        for (int e = 1; e <= 16; e++) begin
            pad_in[5] = (e <= 9) ? pat[e-1] : 1'b1;
            @(negedge clk);
            if (first == 0 && pad_out[5] === 1'b1) first = e;
        end
        checks++;
        if (first != 11) begin
            errors++;
            $display("FAIL glitch_edge got %0d want 11", first);
        end
    endtask

    task automatic test_thresh_lower();
        thresh    = 8'd10;
        pad_in[5] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (pad_out[5] !== 1'b1) begin
            errors++;
            $display("FAIL thr_hold got %b want 1", pad_out[5]);
        end
        thresh = 8'd2;
        @(negedge clk);
        checks++;
        if (pad_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL thr_accept got %b want 0", pad_out[5]);
        end
        @(negedge clk);
        checks++;
        if (fall[5] !== 1'b1) begin
            errors++;
            $display("FAIL thr_fall got %b want 1", fall[5]);
        end
        pad_in[5] = 1'b1;
        repeat (2) @(negedge clk);
        pad_in[5] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (pad_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL thr_cleared got %b want 0", pad_out[5]);
        end
    endtask

`ifdef PAD_IN_FILTER_WKUP_EN
    task automatic test_wkup();
        bit seen;
        filter_en   = '0;
        wkup_en     = 64'h1 << 57;
        pad_in[57]  = 1'b1;
        repeat (6) @(negedge clk);
        wkup_clr = 1'b1;
        @(negedge clk);
        wkup_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (wkup_req !== 1'b0) begin
            errors++;
            $display("FAIL wk_clr got %b want 0", wkup_req);
        end
        pad_in[57] = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (fall[57] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wk_fall_timeout got none want fall");
        end
        @(negedge clk);
        checks++;
        if (wkup_req !== 1'b1) begin
            errors++;
            $display("FAIL wk_set got %b want 1", wkup_req);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wkup_req !== 1'b1) begin
            errors++;
            $display("FAIL wk_sticky got %b want 1", wkup_req);
        end
        wkup_clr = 1'b1;
        @(negedge clk);
        wkup_clr = 1'b0;
        checks++;
        if (wkup_req !== 1'b0) begin
            errors++;
            $display("FAIL wk_clr2 got %b want 0", wkup_req);
        end
        pad_in[57] = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (rise[57] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wk_rise_timeout got none want rise");
        end
        wkup_clr = 1'b1;
        @(negedge clk);
        wkup_clr = 1'b0;
        checks++;
        if (wkup_req !== 1'b1) begin
            errors++;
            $display("FAIL wk_set_wins got %b want 1", wkup_req);
        end
    endtask
`endif

    task automatic test_random();
        logic [NP-1:0] flip;
        for (int c = 0; c < 600; c++) begin
            flip = {$urandom, $urandom} & {$urandom, $urandom}
                 & {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) pad_in = pad_in ^ flip;
            else pad_in = pad_in ^ (flip & {$urandom, $urandom} & {$urandom, $urandom});
            if ($urandom_range(0, 31) == 0) filter_en = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) thresh = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) wkup_en = {$urandom, $urandom};
            wkup_clr = ($urandom_range(0, 7) == 0);
            rst_ni   = !(c == 300);
            @(negedge clk);
            checks++;
            if (pad_out !== m_stable) begin
                errors++;
                $display("FAIL rnd_out c%0d got %h want %h", c, pad_out, m_stable);
            end
            checks++;
            if (rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL rnd_edge c%0d got %h/%h want %h/%h",
                         c, rise, fall, m_rise, m_fall);
            end
`ifdef PAD_IN_FILTER_WKUP_EN
            checks++;
            if (wkup_req !== m_wk) begin
                errors++;
                $display("FAIL rnd_wkup c%0d got %b want %b", c, wkup_req, m_wk);
            end
`endif
        end
        rst_ni   = 1'b1;
        wkup_clr = 1'b0;
    endtask

    initial begin
        rst_ni    = 1'b0;
        pad_in    = '0;
        filter_en = '0;
        thresh    = '0;
        wkup_en   = '0;
        wkup_clr  = 1'b0;
        test_reset();
        test_bypass();
        test_debounce();
        test_glitch();
        test_thresh_lower();
`ifdef PAD_IN_FILTER_WKUP_EN
        test_wkup();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
